// File: rtl/softusb_tx.sv
// softusb_tx: USB 1.1 line transmitter (SYNC, NRZI bit-stuffed data, EOP) with standalone EOP generation
module softusb_tx (
    input  logic       usb_clk,
    input  logic       usb_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    input  logic       low_speed,
    input  logic       generate_eop,
    output logic       txp,
    output logic       txm,
    output logic       txoe
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SYNC    = 3'd1;
    localparam logic [2:0] DATA    = 3'd2;
    localparam logic [2:0] STUFF   = 3'd3;
    localparam logic [2:0] EOP_SE0 = 3'd4;
    localparam logic [2:0] EOP_J   = 3'd5;
    logic [2:0] state_q, state_d;
    logic       ls_q, ls_d;
    logic       lvl_q, lvl_d;
    logic [5:0] per_q, per_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] ones_q, ones_d;
    logic       txp_q, txp_d, txm_q, txm_d, txoe_q, txoe_d, ready_q, ready_d, busy_q, busy_d;
    logic       bit_end, se0_end, send, nb, fetch, j_p;
    assign bit_end  = per_q == (ls_q ? 6'd31 : 6'd3);
    assign se0_end  = per_q == (ls_q ? 6'd63 : 6'd7);
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign txp      = txp_q;
    assign txm      = txm_q;
    assign txoe     = txoe_q;
    // next bit selection, stuffing, byte fetch and NRZI level; lvl=1 means J
    always_comb begin
        state_d = state_q;
        ls_d    = ls_q;
        lvl_d   = lvl_q;
        per_d   = per_q + 6'd1;
        bit_d   = bit_q;
        sr_d    = sr_q;
        ones_d  = ones_q;
        ready_d = 1'b0;
        send    = 1'b0;
        nb      = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            IDLE: begin
                per_d  = '0;
                bit_d  = '0;
                ones_d = '0;
                lvl_d  = 1'b1;
                if (tx_valid) begin
                    ls_d    = low_speed;
                    lvl_d   = 1'b0;
                    state_d = SYNC;
                end else if (generate_eop) begin
                    ls_d    = low_speed;
                    state_d = EOP_SE0;
                end
            end
            SYNC: if (bit_end) begin
                send  = 1'b1;
                bit_d = bit_q + 3'd1;
                nb    = bit_q == 3'd6;
                fetch = bit_q == 3'd7;
            end
            DATA, STUFF: if (bit_end) begin
                send    = 1'b1;
                state_d = DATA;
                bit_d   = bit_q + 3'd1;
                sr_d    = {1'b0, sr_q[7:1]};
                nb      = sr_q[1];
                if (state_q == DATA && ones_q == 3'd6) begin
                    state_d = STUFF;
                    bit_d   = bit_q;
                    sr_d    = sr_q;
                    nb      = 1'b0;
                end else begin
                    fetch = bit_q == 3'd7;
                end
            end
            EOP_SE0: if (se0_end) begin
                state_d = EOP_J;
                per_d   = '0;
            end
            EOP_J: if (bit_end) begin
                state_d = IDLE;
                per_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (fetch) begin
            if (tx_valid) begin
                state_d = DATA;
                sr_d    = tx_data;
                bit_d   = '0;
                nb      = tx_data[0];
                ready_d = 1'b1;
            end else begin
                send    = 1'b0;
                state_d = EOP_SE0;
                per_d   = '0;
                lvl_d   = 1'b1;
            end
        end
        if (send) begin
            per_d  = '0;
            lvl_d  = nb ? lvl_q : ~lvl_q;
            ones_d = nb ? ones_q + 3'd1 : 3'd0;
        end
        j_p     = state_d == IDLE ? ~low_speed : lvl_d ^ ls_d;
        txp_d   = state_d != EOP_SE0 && j_p;
        txm_d   = state_d != EOP_SE0 && !j_p;
        txoe_d  = state_d != IDLE;
        busy_d  = state_d != IDLE;
    end
    // state and registered line outputs, cleared asynchronously
    always_ff @(posedge usb_clk or negedge usb_rst_n) begin
        if (!usb_rst_n) begin
            state_q <= IDLE;
            ls_q    <= 1'b0;
            lvl_q   <= 1'b1;
            per_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            ones_q  <= '0;
            txp_q   <= 1'b1;
            txm_q   <= 1'b0;
            txoe_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ls_q    <= ls_d;
            lvl_q   <= lvl_d;
            per_q   <= per_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            ones_q  <= ones_d;
            txp_q   <= txp_d;
            txm_q   <= txm_d;
            txoe_q  <= txoe_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end
endmodule
